// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard unit: forwarding selects and the
// memory-wait FSM state encoding.
package hazard_pkg;

   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,
      FWD_WB  = 2'b01,
      FWD_MEM = 2'b10
   } fwd_sel_t;

   typedef enum logic [1:0] {
      ST_RUN,
      ST_WAIT,
      ST_RELEASE
   } hz_state_t;

   // M-stage result wins over W-stage; register 0 is never forwarded.
   function automatic fwd_sel_t fwd_sel(input logic [4:0] src,
                                        input logic [4:0] wreg_m,
                                        input logic       rw_m,
                                        input logic [4:0] wreg_w,
                                        input logic       rw_w);
      fwd_sel_t sel;
      sel = FWD_RF;
      if (src != 5'd0 && src == wreg_m && rw_m)
         sel = FWD_MEM;
      else if (src != 5'd0 && src == wreg_w && rw_w)
         sel = FWD_WB;
      return sel;
   endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// Pipeline-to-hazard-unit bundle: register ids and control bits in,
// forwarding selects, stall/flush controls and status out.
interface hazard_unit_if #(parameter int CNT_W = 16);
   import hazard_pkg::*;

   logic [4:0]       rsD, rtD, rsE, rtE;
   logic [4:0]       writeregE, writeregM, writeregW;
   logic             branchD, memtoregE, memtoregM;
   logic             regwriteE, regwriteM, regwriteW;
   logic             memwriteM, dmem_ready;
   logic             forwardAD, forwardBD;
   fwd_sel_t         forwardAE, forwardBE;
   logic             stallF, stallD, stallE, stallM;
   logic             flushE, flushW;
   logic             mem_timeout;
   logic [CNT_W-1:0] stall_count;

   modport master (
      output rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW,
             branchD, memtoregE, memtoregM, regwriteE, regwriteM, regwriteW,
             memwriteM, dmem_ready,
      input  forwardAD, forwardBD, forwardAE, forwardBE,
             stallF, stallD, stallE, stallM, flushE, flushW,
             mem_timeout, stall_count
   );

   modport slave (
      input  rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW,
             branchD, memtoregE, memtoregM, regwriteE, regwriteM, regwriteW,
             memwriteM, dmem_ready,
      output forwardAD, forwardBD, forwardAE, forwardBE,
             stallF, stallD, stallE, stallM, flushE, flushW,
             mem_timeout, stall_count
   );
endinterface

// File: rtl/hazard_unit_sat_counter.sv
// Saturating up-counter with enable and synchronous active-low clear;
// holds at all-ones instead of wrapping.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         i_clk,
   input  logic         i_clr_n,
   input  logic         i_en,
   output logic [W-1:0] o_count
);

   logic [W-1:0] r_count;

   always_ff @(posedge i_clk) begin
      if (!i_clr_n)
         r_count <= '0;
      else if (i_en && r_count != {W{1'b1}})
         r_count <= r_count + 1'b1;
   end

   assign o_count = r_count;

endmodule

// File: rtl/hazard_unit.sv
// Forwarding and stall/flush control for a 5-stage pipeline, zero-cycle latency.
// Slow data memory stalls the whole pipe, bounded by MAX_WAIT before a forced one-cycle release.
module hazard_unit
   import hazard_pkg::*;
#(
   parameter int MAX_WAIT = 15,
   parameter int CNT_W    = 16
) (
   input logic          clk,
   input logic          reset,
   hazard_unit_if.slave hz
);

   localparam int WCNT_W = ($clog2(MAX_WAIT + 1) > 4) ? $clog2(MAX_WAIT + 1) : 4;
   localparam logic [WCNT_W-1:0] WAIT_LIM = WCNT_W'(MAX_WAIT);

   hz_state_t         r_state;
   logic [WCNT_W-1:0] r_wait_cnt;
   logic              r_mem_timeout;

   logic              w_memreq;
   logic              w_release;
   logic              w_lwstall;
   logic              w_branchstall;
   logic              w_memstall;
   logic              w_hazstall;
   logic [WCNT_W-1:0] w_wait_nxt;

   assign w_memreq   = hz.memtoregM | hz.memwriteM;
   // While reset is held the unit behaves as if in RUN.
   assign w_release  = reset && (r_state == ST_RELEASE);
   assign w_wait_nxt = r_wait_cnt + 1'b1;

   assign w_lwstall  = hz.memtoregE & ((hz.rsD == hz.rtE) | (hz.rtD == hz.rtE));
   assign w_branchstall = hz.branchD &
      ((hz.regwriteE & ((hz.writeregE == hz.rsD) | (hz.writeregE == hz.rtD))) |
       (hz.memtoregM & ((hz.writeregM == hz.rsD) | (hz.writeregM == hz.rtD))));
   assign w_memstall = w_memreq & ~hz.dmem_ready & ~w_release;
   assign w_hazstall = w_lwstall | w_branchstall;

   assign hz.forwardAE = fwd_sel(hz.rsE, hz.writeregM, hz.regwriteM, hz.writeregW, hz.regwriteW);
   assign hz.forwardBE = fwd_sel(hz.rtE, hz.writeregM, hz.regwriteM, hz.writeregW, hz.regwriteW);
   assign hz.forwardAD = (hz.rsD != 5'd0) & (hz.rsD == hz.writeregM) & hz.regwriteM;
   assign hz.forwardBD = (hz.rtD != 5'd0) & (hz.rtD == hz.writeregM) & hz.regwriteM;

   // A memory stall freezes every stage, so the E bubble is suppressed and W is flushed instead.
   assign hz.stallF = w_memstall | w_hazstall;
   assign hz.stallD = w_memstall | w_hazstall;
   assign hz.flushE = ~w_memstall & w_hazstall;
   assign hz.stallE = w_memstall;
   assign hz.stallM = w_memstall;
   assign hz.flushW = w_memstall;

   assign hz.mem_timeout = r_mem_timeout;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state       <= ST_RUN;
         r_wait_cnt    <= '0;
         r_mem_timeout <= 1'b0;
      end else begin
         case (r_state)
            ST_RUN: begin
               if (w_memreq && !hz.dmem_ready) begin
                  if (WAIT_LIM <= WCNT_W'(1)) begin
                     r_state       <= ST_RELEASE;
                     r_wait_cnt    <= '0;
                     r_mem_timeout <= 1'b1;
                  end else begin
                     r_state    <= ST_WAIT;
                     r_wait_cnt <= WCNT_W'(1);
                  end
               end
            end
            ST_WAIT: begin
               if (hz.dmem_ready || !w_memreq) begin
                  r_state    <= ST_RUN;
                  r_wait_cnt <= '0;
               end else if (w_wait_nxt >= WAIT_LIM) begin
                  // The counter tracks stalled cycles; reaching the limit here
                  // means MAX_WAIT stall cycles have been spent on this access.
                  r_state       <= ST_RELEASE;
                  r_wait_cnt    <= '0;
                  r_mem_timeout <= 1'b1;
               end else begin
                  r_wait_cnt <= w_wait_nxt;
               end
            end
            ST_RELEASE: begin
               r_state    <= ST_RUN;
               r_wait_cnt <= '0;
            end
            default: begin
               r_state    <= ST_RUN;
               r_wait_cnt <= '0;
            end
         endcase
      end
   end

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .i_clk   (clk),
      .i_clr_n (reset),
      .i_en    (hz.stallF),
      .o_count (hz.stall_count)
   );

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: directed vector table, corner-case sequences and
// randomized traffic against a cycle-level reference model.
module tb_hazard_unit;
   import hazard_pkg::*;

   localparam int MW = 15;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   hazard_unit_if #(.CNT_W(16)) hz1 ();
   hazard_unit_if #(.CNT_W(4))  hz2 ();

   hazard_unit #(.MAX_WAIT(MW), .CNT_W(16)) dut1 (.clk(clk), .reset(reset), .hz(hz1));
   hazard_unit #(.MAX_WAIT(MW), .CNT_W(4))  dut2 (.clk(clk), .reset(reset), .hz(hz2));

   assign hz2.rsD = hz1.rsD;             assign hz2.rtD = hz1.rtD;
   assign hz2.rsE = hz1.rsE;             assign hz2.rtE = hz1.rtE;
   assign hz2.writeregE = hz1.writeregE; assign hz2.writeregM = hz1.writeregM;
   assign hz2.writeregW = hz1.writeregW; assign hz2.branchD = hz1.branchD;
   assign hz2.memtoregE = hz1.memtoregE; assign hz2.memtoregM = hz1.memtoregM;
   assign hz2.regwriteE = hz1.regwriteE; assign hz2.regwriteM = hz1.regwriteM;
   assign hz2.regwriteW = hz1.regwriteW; assign hz2.memwriteM = hz1.memwriteM;
   assign hz2.dmem_ready = hz1.dmem_ready;

   typedef struct packed {
      logic [4:0] rsD, rtD, rsE, rtE, wE, wM, wW;
      logic br, mtE, mtM, rwE, rwM, rwW, mwM, rdy;
   } in_t;

   typedef struct packed {
      logic [1:0] fAE, fBE;
      logic fAD, fBD, sF, fE, sM, fW;
   } exp_t;

   typedef struct packed {
      in_t  i;
      exp_t e;
   } vec_t;

   int checks = 0;
   int errors = 0;

   // Reference model state: stalled cycles on the current access, release pending,
   // sticky timeout and the two stall counters (16-bit and 4-bit instances).
   int m_waited = 0;
   bit m_rel = 1'b0;
   bit m_to = 1'b0;
   int m_cnt1 = 0;
   int m_cnt2 = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, expv);
      end
   endtask

   task automatic apply(input in_t v);
      hz1.rsD = v.rsD; hz1.rtD = v.rtD; hz1.rsE = v.rsE; hz1.rtE = v.rtE;
      hz1.writeregE = v.wE; hz1.writeregM = v.wM; hz1.writeregW = v.wW;
      hz1.branchD = v.br; hz1.memtoregE = v.mtE; hz1.memtoregM = v.mtM;
      hz1.regwriteE = v.rwE; hz1.regwriteM = v.rwM; hz1.regwriteW = v.rwW;
      hz1.memwriteM = v.mwM; hz1.dmem_ready = v.rdy;
   endtask

   function automatic in_t cur_in();
      in_t v;
      v.rsD = hz1.rsD; v.rtD = hz1.rtD; v.rsE = hz1.rsE; v.rtE = hz1.rtE;
      v.wE = hz1.writeregE; v.wM = hz1.writeregM; v.wW = hz1.writeregW;
      v.br = hz1.branchD; v.mtE = hz1.memtoregE; v.mtM = hz1.memtoregM;
      v.rwE = hz1.regwriteE; v.rwM = hz1.regwriteM; v.rwW = hz1.regwriteW;
      v.mwM = hz1.memwriteM; v.rdy = hz1.dmem_ready;
      return v;
   endfunction

   function automatic logic [1:0] m_fwd(input logic [4:0] s, input in_t v);
      if (s != 0 && s == v.wM && v.rwM) return 2'd2;
      if (s != 0 && s == v.wW && v.rwW) return 2'd1;
      return 2'd0;
   endfunction

   function automatic exp_t m_exp(input in_t v, input bit rst_n, input bit rel);
      exp_t e;
      bit lw, br, ms;
      lw = v.mtE && (v.rsD == v.rtE || v.rtD == v.rtE);
      br = v.br && ((v.rwE && (v.wE == v.rsD || v.wE == v.rtD)) ||
                    (v.mtM && (v.wM == v.rsD || v.wM == v.rtD)));
      ms = (v.mtM || v.mwM) && !v.rdy && !(rel && rst_n);
      e.fAE = m_fwd(v.rsE, v);
      e.fBE = m_fwd(v.rtE, v);
      e.fAD = (v.rsD != 0) && v.rsD == v.wM && v.rwM;
      e.fBD = (v.rtD != 0) && v.rtD == v.wM && v.rwM;
      e.sF  = ms || lw || br;
      e.fE  = !ms && (lw || br);
      e.sM  = ms;
      e.fW  = ms;
      return e;
   endfunction

   task automatic check_model();
      exp_t e;
      e = m_exp(cur_in(), reset, m_rel);
      chk("m.forwardAE", hz1.forwardAE, e.fAE);
      chk("m.forwardBE", hz1.forwardBE, e.fBE);
      chk("m.forwardAD", hz1.forwardAD, e.fAD);
      chk("m.forwardBD", hz1.forwardBD, e.fBD);
      chk("m.stallF", hz1.stallF, e.sF);
      chk("m.stallD", hz1.stallD, e.sF);
      chk("m.flushE", hz1.flushE, e.fE);
      chk("m.stallE", hz1.stallE, e.sM);
      chk("m.stallM", hz1.stallM, e.sM);
      chk("m.flushW", hz1.flushW, e.fW);
      chk("m.mem_timeout", hz1.mem_timeout, m_to);
      chk("m.stall_count16", hz1.stall_count, m_cnt1);
      chk("m.stall_count4", hz2.stall_count, m_cnt2);
   endtask

   task automatic at_neg();
      @(negedge clk);
      check_model();
   endtask

   task automatic clk_edge();
      exp_t e;
      e = m_exp(cur_in(), reset, m_rel);
      @(posedge clk);
      if (!reset) begin
         m_waited = 0; m_rel = 0; m_to = 0; m_cnt1 = 0; m_cnt2 = 0;
      end else begin
         if (e.sF) begin
            m_cnt1 = (m_cnt1 < 65535) ? m_cnt1 + 1 : 65535;
            m_cnt2 = (m_cnt2 < 15) ? m_cnt2 + 1 : 15;
         end
         if (m_rel) begin
            m_rel = 0;
            m_waited = 0;
         end else if (e.sM) begin
            m_waited++;
            if (m_waited >= MW) begin
               m_rel = 1; m_to = 1; m_waited = 0;
            end
         end else begin
            m_waited = 0;
         end
      end
      #1;
   endtask

   task automatic cyc();
      at_neg();
      clk_edge();
   endtask

   task automatic do_reset();
      reset = 1'b0;
      cyc();
      reset = 1'b1;
   endtask

   vec_t tv[15];
   in_t  idle, v;

   initial begin
      //          rsD rtD rsE rtE wE wM wW  br mtE mtM rwE rwM rwW mwM rdy   fAE fBE fAD fBD sF fE sM fW
      tv[0]  = '{'{0, 0, 5, 0, 0, 5, 5,  0, 0, 0, 0, 1, 1, 0, 1}, '{2, 0, 0, 0, 0, 0, 0, 0}};
      tv[1]  = '{'{0, 0, 0, 0, 0, 5, 5,  0, 0, 0, 0, 1, 1, 0, 1}, '{0, 0, 0, 0, 0, 0, 0, 0}};
      tv[2]  = '{'{0, 0, 7, 7, 0, 3, 7,  0, 0, 0, 0, 1, 1, 0, 1}, '{1, 1, 0, 0, 0, 0, 0, 0}};
      tv[3]  = '{'{0, 0, 7, 0, 0, 0, 7,  0, 0, 0, 0, 0, 0, 0, 1}, '{0, 0, 0, 0, 0, 0, 0, 0}};
      tv[4]  = '{'{0, 0, 0, 9, 0, 9, 9,  0, 0, 0, 0, 0, 1, 0, 1}, '{0, 1, 0, 0, 0, 0, 0, 0}};
      tv[5]  = '{'{8, 0, 0, 8, 0, 0, 0,  0, 1, 0, 0, 0, 0, 0, 1}, '{0, 0, 0, 0, 1, 1, 0, 0}};
      tv[6]  = '{'{1, 4, 0, 4, 0, 0, 0,  0, 1, 0, 0, 0, 0, 0, 1}, '{0, 0, 0, 0, 1, 1, 0, 0}};
      tv[7]  = '{'{5, 6, 0, 4, 0, 0, 0,  0, 1, 0, 0, 0, 0, 0, 1}, '{0, 0, 0, 0, 0, 0, 0, 0}};
      tv[8]  = '{'{3, 0, 0, 0, 3, 0, 0,  1, 0, 0, 1, 0, 0, 0, 1}, '{0, 0, 0, 0, 1, 1, 0, 0}};
      tv[9]  = '{'{3, 0, 0, 0, 3, 3, 0,  1, 0, 0, 0, 1, 0, 0, 1}, '{0, 0, 1, 0, 0, 0, 0, 0}};
      tv[10] = '{'{0, 6, 0, 0, 0, 6, 0,  1, 0, 1, 0, 0, 0, 0, 1}, '{0, 0, 0, 0, 1, 1, 0, 0}};
      tv[11] = '{'{2, 0, 0, 2, 2, 0, 0,  1, 1, 0, 1, 0, 0, 0, 1}, '{0, 0, 0, 0, 1, 1, 0, 0}};
      tv[12] = '{'{4, 4, 0, 0, 0, 4, 0,  0, 0, 0, 0, 1, 0, 0, 1}, '{0, 0, 1, 1, 0, 0, 0, 0}};
      tv[13] = '{'{0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 0, 0, 1}, '{0, 0, 0, 0, 0, 0, 0, 0}};
      tv[14] = '{'{1, 0, 0, 1, 0, 0, 0,  0, 1, 0, 0, 0, 0, 1, 1}, '{0, 0, 0, 0, 1, 1, 0, 0}};

      idle = '0;
      idle.rdy = 1'b1;
      apply(idle);

      // Reset state
      reset = 1'b0;
      at_neg();
      chk("rst.mem_timeout", hz1.mem_timeout, 0);
      chk("rst.stall_count", hz1.stall_count, 0);
      chk("rst.stallM", hz1.stallM, 0);
      clk_edge();
      reset = 1'b1;

      for (int k = 0; k < 15; k++) begin
         apply(tv[k].i);
         at_neg();
         chk($sformatf("vec%0d.forwardAE", k), hz1.forwardAE, tv[k].e.fAE);
         chk($sformatf("vec%0d.forwardBE", k), hz1.forwardBE, tv[k].e.fBE);
         chk($sformatf("vec%0d.forwardAD", k), hz1.forwardAD, tv[k].e.fAD);
         chk($sformatf("vec%0d.forwardBD", k), hz1.forwardBD, tv[k].e.fBD);
         chk($sformatf("vec%0d.stallF", k), hz1.stallF, tv[k].e.sF);
         chk($sformatf("vec%0d.stallD", k), hz1.stallD, tv[k].e.sF);
         chk($sformatf("vec%0d.flushE", k), hz1.flushE, tv[k].e.fE);
         chk($sformatf("vec%0d.stallM", k), hz1.stallM, tv[k].e.sM);
         chk($sformatf("vec%0d.flushW", k), hz1.flushW, tv[k].e.fW);
         clk_edge();
      end

      // Load-use stall bumps the counter by one; a combined lw+branch stall also by one.
      apply(idle);
      do_reset();
      apply(tv[5].i);
      at_neg();
      chk("lw.count_before", hz1.stall_count, 0);
      clk_edge();
      apply(idle);
      at_neg();
      chk("lw.count_after", hz1.stall_count, 1);
      chk("lw.stall_gone", hz1.stallF, 0);
      clk_edge();
      apply(tv[11].i);
      cyc();
      apply(idle);
      at_neg();
      chk("lw_br.count", hz1.stall_count, 2);
      clk_edge();

      // Load waits 3 cycles for memory, then completes.
      v = idle; v.mtM = 1'b1; v.wM = 5'd9; v.rdy = 1'b0;
      apply(v);
      for (int i = 0; i < 3; i++) begin
         at_neg();
         chk($sformatf("wait3.stallM%0d", i), hz1.stallM, 1);
         chk($sformatf("wait3.stallE%0d", i), hz1.stallE, 1);
         chk($sformatf("wait3.flushW%0d", i), hz1.flushW, 1);
         chk($sformatf("wait3.flushE%0d", i), hz1.flushE, 0);
         clk_edge();
      end
      v.rdy = 1'b1;
      apply(v);
      at_neg();
      chk("wait3.done_stallM", hz1.stallM, 0);
      chk("wait3.timeout", hz1.mem_timeout, 0);
      clk_edge();
      apply(idle);
      cyc();

      // Store never acknowledged, with a load-use hazard in decode at the same time.
      begin
         int  n;
         bit  done;
         n = 0;
         done = 1'b0;
         v = idle; v.mwM = 1'b1; v.rdy = 1'b0; v.mtE = 1'b1; v.rsD = 5'd1; v.rtE = 5'd1;
         apply(v);
         for (int i = 0; i < 40 && !done; i++) begin
            at_neg();
            if (hz1.stallM) begin
               if (i == 0) begin
                  chk("to.lw_flushE", hz1.flushE, 0);
                  chk("to.lw_flushW", hz1.flushW, 1);
               end
               n++;
               clk_edge();
            end else begin
               done = 1'b1;
            end
         end
         chk("to.stall_cycles", n, MW);
         chk("to.release_stallM", hz1.stallM, 0);
         chk("to.release_flushE", hz1.flushE, 1);
         chk("to.flag", hz1.mem_timeout, 1);
         clk_edge();
         at_neg();
         chk("to.restart_stallM", hz1.stallM, 1);
         clk_edge();
         apply(idle);
         for (int i = 0; i < 3; i++) cyc();
         at_neg();
         chk("to.sticky", hz1.mem_timeout, 1);
         clk_edge();
         do_reset();
         at_neg();
         chk("to.rst_flag", hz1.mem_timeout, 0);
         chk("to.rst_count", hz1.stall_count, 0);
         clk_edge();
      end

      // Long load-use stall: the 4-bit counter pins at 15.
      apply(tv[5].i);
      for (int i = 0; i < 20; i++) cyc();
      apply(idle);
      at_neg();
      chk("sat.count4", hz2.stall_count, 15);
      chk("sat.count16", hz1.stall_count, 20);
      clk_edge();

      // Reset in the middle of a wait forgets the pending access.
      v = idle; v.mtM = 1'b1; v.rdy = 1'b0;
      apply(v);
      for (int i = 0; i < 3; i++) cyc();
      reset = 1'b0;
      at_neg();
      chk("midrst.stallM_in_reset", hz1.stallM, 1);
      clk_edge();
      reset = 1'b1;
      at_neg();
      chk("midrst.stallM_after", hz1.stallM, 1);
      chk("midrst.timeout", hz1.mem_timeout, 0);
      clk_edge();
      apply(idle);
      cyc();

      // Randomized traffic against the model, with occasional stuck-memory bursts.
      begin
         int stuck;
         stuck = 0;
         for (int n = 0; n < 3000; n++) begin
            v.rsD = 5'($urandom_range(0, 3)); v.rtD = 5'($urandom_range(0, 3));
            v.rsE = 5'($urandom_range(0, 3)); v.rtE = 5'($urandom_range(0, 3));
            v.wE  = 5'($urandom_range(0, 3)); v.wM  = 5'($urandom_range(0, 3));
            v.wW  = 5'($urandom_range(0, 3));
            v.br  = ($urandom % 4) == 0;      v.mtE = ($urandom % 4) == 0;
            v.mtM = ($urandom % 4) == 0;      v.mwM = ($urandom % 8) == 0;
            v.rwE = $urandom % 2;             v.rwM = $urandom % 2;
            v.rwW = $urandom % 2;             v.rdy = ($urandom % 4) != 0;
            if (stuck == 0 && ($urandom % 150) == 0) stuck = 20;
            if (stuck > 0) begin
               v.mwM = 1'b1;
               v.rdy = 1'b0;
               stuck--;
            end
            apply(v);
            reset = (($urandom % 250) != 0);
            cyc();
         end
         reset = 1'b1;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 The module SHALL have parameter MAX_WAIT, default 15: maximum consecutive memory-wait stall cycles before forced release.
REQ-002 The module SHALL have parameter CNT_W, default 16: width of the stall-cycle counter.
REQ-003 The module SHALL have these ports (name, direction, width, meaning), clock and reset first:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- rsD, rtD  in  5  decode-stage source registers.
- rsE, rtE  in  5  execute-stage source registers.
- writeregE, writeregM, writeregW  in  5  destination register per stage.
- branchD  in  1  branch instruction in decode.
- memtoregE, memtoregM  in  1  load instruction in E and M.
- regwriteE, regwriteM, regwriteW  in  1  register write pending in E, M and W.
- memwriteM  in  1  store in M.
- dmem_ready  in  1  data memory acknowledge for the current M-stage access.
- forwardAD, forwardBD  out  1  decode comparator forward from M.
- forwardAE, forwardBE  out  2  ALU operand select.
- stallF, stallD, stallE, stallM  out  1  hold the pipeline register of that stage.
- flushE, flushW  out  1  insert a bubble into E and W.
- mem_timeout  out  1  sticky error flag: wait limit hit.
- stall_count  out  CNT_W  saturating count of cycles with stallF=1.

Function
REQ-004 forwardAE SHALL be 2'b10 if rsE!=0, rsE==writeregM and regwriteM; else 2'b01 if rsE!=0, rsE==writeregW and regwriteW; else 2'b00. forwardBE SHALL follow the same rule using rtE.
REQ-005 forwardAD SHALL be (rsD!=0 & rsD==writeregM & regwriteM). forwardBD SHALL follow the same rule using rtD.
REQ-006 lwstall SHALL be memtoregE & (rsD==rtE | rtD==rtE).
REQ-007 branchstall SHALL be branchD & ((regwriteE & (writeregE==rsD | writeregE==rtD)) | (memtoregM & (writeregM==rsD | writeregM==rtD))).
REQ-008 memreq SHALL be memtoregM | memwriteM. memstall SHALL be memreq & !dmem_ready & !release, where release is set in state RELEASE.
REQ-009 memstall SHALL take priority: stallF, stallD, stallE and stallM SHALL be 1, flushW SHALL be 1 and flushE SHALL be 0.
REQ-010 If memstall is 0: stallF = stallD = flushE = lwstall | branchstall; stallE, stallM and flushW SHALL be 0.
REQ-011 The FSM SHALL have states RUN, WAIT and RELEASE. The internal wait counter is 4 bits minimum, sized to hold MAX_WAIT.
REQ-012 RUN -> WAIT SHALL occur when memreq & !dmem_ready; the wait counter loads 1.
REQ-013 WAIT -> RUN SHALL occur on dmem_ready or !memreq; the wait counter clears.
REQ-014 In WAIT, with no exit condition, the wait counter SHALL increment. When the counter equals MAX_WAIT and the access is still not ready, the FSM SHALL go WAIT -> RELEASE and set mem_timeout.
REQ-015 In RELEASE, memstall SHALL be 0 for exactly one cycle, then RELEASE -> RUN. The next access that waits restarts the count.
REQ-016 mem_timeout SHALL remain 1 until reset.
REQ-017 stall_count SHALL increment on every cycle with stallF=1 and SHALL saturate at all-ones with no wrap-around.
REQ-018 When lwstall and branchstall occur together, a single stall cycle SHALL result and the counter SHALL increment by 1.
REQ-019 All forwarding and stall outputs SHALL be combinational from inputs and current state. The latency from the hazard condition to the stall output is zero cycles.

Reset
REQ-020 On a clock edge with reset=0, the FSM SHALL go to RUN, and the wait counter, mem_timeout and stall_count SHALL clear to 0.
REQ-021 Reset SHALL take effect mid-wait, with no memory of the pending access.
REQ-022 During reset, the combinational outputs SHALL still follow REQ-004 to REQ-010 using the reset state, in which release is 0.

Structure
REQ-023 Package hazard_pkg SHALL hold fwd_sel_t (FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10) and the FSM state enum hz_state_t.
REQ-024 One sub-module, sat_counter #(W), SHALL implement the saturating stall_count with enable and synchronous active-low clear.
REQ-025 All other logic SHALL be flat in hazard_unit.

Verification
REQ-026 rsE=5, writeregM=5, regwriteM=1, writeregW=5, regwriteW=1 -> forwardAE=2'b10. Same case with rsE=0 -> forwardAE=2'b00.
REQ-027 memtoregE=1, rtE=8, rsD=8 -> stallF=stallD=flushE=1 for 1 cycle, and stall_count goes from 0 to 1.
REQ-028 branchD=1, rsD=3, regwriteE=1, writeregE=3 -> stallF=1 and flushE=1. Next cycle, with regwriteE=0 and memtoregM=0 -> forwardAD follows REQ-005 and no stall.
REQ-029 memtoregM=1, dmem_ready=0 for 3 cycles then 1 -> stallF/D/E/M=1 and flushW=1 for exactly 3 cycles, then RUN, with mem_timeout=0.
REQ-030 memwriteM=1, dmem_ready held 0, MAX_WAIT=15 -> 15 stall cycles, one release cycle with stallM=0, mem_timeout=1 and sticky. reset=0 for one edge -> mem_timeout=0 and stall_count=0.
REQ-031 CNT_W=4, stall held for 20 cycles -> stall_count saturates at 4'hF. Also, lwstall asserted during memstall -> flushE=0 and flushW=1.
